// File: rtl/mu0_pkg.sv
// mu0_pkg: shared definitions for the MU0 accumulator CPU.
//   - opcode encodings OP_LDA..OP_STP (instr[15:12])
//   - FSM state encoding and ALU operation encoding
//   - default address width and a decode helper for memory-accessing opcodes
package mu0_pkg;

  localparam int ADDR_W_DEF = 12;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STO = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JGE = 4'h5;
  localparam logic [3:0] OP_JNE = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ALU_PASS = 2'd0,
    ALU_ADD  = 2'd1,
    ALU_SUB  = 2'd2
  } alu_op_t;

  // LDA, STO, ADD and SUB are the only opcodes that touch memory in EXEC.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op <= OP_SUB);
  endfunction

endpackage

// File: rtl/mu0_alu.sv
// mu0_alu: combinational 16-bit datapath for the MU0 accumulator.
// Ports:
//   op  in  alu_op_t  PASS (y=b), ADD (y=a+b), SUB (y=a-b); carry/borrow dropped
//   a   in  16        accumulator value
//   b   in  16        memory read data
//   y   out 16        result to be loaded into the accumulator
module mu0_alu
  import mu0_pkg::*;
(
  input  alu_op_t     op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);

  // Select pass-through, modulo add or modulo subtract.
  always_comb begin
    y = b;
    case (op)
      ALU_PASS: y = b;
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      default:  y = b;
    endcase
  end

endmodule

// File: rtl/mu0_core.sv
// mu0_core: MU0 accumulator CPU, sole master of a combinational 16-bit word memory.
// Fetch/execute FSM: FETCH reads the instruction at pc, EXEC performs the operand
// access (LDA/STO/ADD/SUB) or the control action (JMP/JGE/JNE/STP/NOP).
// Each memory access is held for WAIT_CYCLES+1 cycles; data is taken on the last one.
// Optional feature macro: MU0_SINGLE_STEP_EN adds the stepRq input; FETCH then
// idles (memRq=0) until stepRq is seen, and runs exactly one instruction per request.
// Ports:
//   clk, reset           clock (rising edge), synchronous active-high reset
//   stepRq               single-step request (only with MU0_SINGLE_STEP_EN)
//   memRq, readNotWrite  memory request and direction (1 = read)
//   addr                 word address {zero-extend, pc or operand}
//   dataOut / dataIn     write data (= acc) / read data
//   halted, acc, pc      status and debug views
module mu0_core
  import mu0_pkg::*;
#(
  parameter int                ADDR_W      = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
`ifdef MU0_SINGLE_STEP_EN
  input  logic              stepRq,
`endif
  output logic              memRq,
  output logic              readNotWrite,
  output logic [15:0]       addr,
  output logic [15:0]       dataOut,
  input  logic [15:0]       dataIn,
  output logic              halted,
  output logic [15:0]       acc,
  output logic [ADDR_W-1:0] pc
);

  localparam int              WC_W      = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(WAIT_CYCLES);

  state_t              state_r;
  logic [WC_W-1:0]     wait_cnt_r;
  logic [15:0]         ir_r;
  logic [15:0]         acc_r;
  logic [ADDR_W-1:0]   pc_r;
  logic                halted_r;

  logic [3:0]          opcode;
  logic [ADDR_W-1:0]   operand;
  logic                last_cycle;
  logic                fetch_en;
  alu_op_t             alu_op;
  logic [15:0]         alu_y;

  assign opcode     = ir_r[15:12];
  assign operand    = ir_r[ADDR_W-1:0];
  assign last_cycle = (wait_cnt_r == WAIT_LAST);

`ifdef MU0_SINGLE_STEP_EN
  // Remembers an accepted step request so a multi-cycle fetch keeps going after stepRq drops.
  logic step_go_r;
  assign fetch_en = step_go_r | stepRq;

  // Arm on a request seen in FETCH, disarm when the instruction's EXEC completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      step_go_r <= 1'b0;
    end else if (state_r == ST_FETCH && stepRq) begin
      step_go_r <= 1'b1;
    end else if (state_r == ST_EXEC && (!is_mem_op(opcode) || last_cycle)) begin
      step_go_r <= 1'b0;
    end else begin
      step_go_r <= step_go_r;
    end
  end
`else
  assign fetch_en = 1'b1;
`endif

  // ALU operation follows the opcode; LDA and everything else pass dataIn through.
  always_comb begin
    alu_op = ALU_PASS;
    case (opcode)
      OP_ADD:  alu_op = ALU_ADD;
      OP_SUB:  alu_op = ALU_SUB;
      default: alu_op = ALU_PASS;
    endcase
  end

  mu0_alu u_alu (
    .op (alu_op),
    .a  (acc_r),
    .b  (dataIn),
    .y  (alu_y)
  );

  // Bus decode from state/ir; the memory is combinational so these cannot be registered.
  always_comb begin
    memRq        = 1'b0;
    readNotWrite = 1'b1;
    addr         = 16'(operand);
    if (reset) begin
      memRq = 1'b0;
    end else begin
      case (state_r)
        ST_FETCH: memRq = fetch_en;
        ST_EXEC:  memRq = is_mem_op(opcode);
        default:  memRq = 1'b0;
      endcase
    end
    if (state_r == ST_EXEC && opcode == OP_STO) begin
      readNotWrite = 1'b0;
    end else begin
      readNotWrite = 1'b1;
    end
    if (state_r == ST_FETCH) begin
      addr = 16'(pc_r);
    end else begin
      addr = 16'(operand);
    end
  end

  assign dataOut = acc_r;
  assign acc     = acc_r;
  assign pc      = pc_r;
  assign halted  = halted_r;

  // Fetch/execute FSM with the architectural registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_FETCH;
      wait_cnt_r <= '0;
      ir_r       <= 16'h0000;
      acc_r      <= 16'h0000;
      pc_r       <= RESET_PC;
      halted_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (fetch_en) begin
            if (last_cycle) begin
              ir_r       <= dataIn;
              pc_r       <= pc_r + ADDR_W'(1);
              wait_cnt_r <= '0;
              state_r    <= ST_EXEC;
            end else begin
              wait_cnt_r <= wait_cnt_r + WC_W'(1);
            end
          end else begin
            wait_cnt_r <= '0;
          end
        end
        ST_EXEC: begin
          if (is_mem_op(opcode)) begin
            if (last_cycle) begin
              if (opcode != OP_STO) begin
                acc_r <= alu_y;
              end else begin
                acc_r <= acc_r;
              end
              wait_cnt_r <= '0;
              state_r    <= ST_FETCH;
            end else begin
              wait_cnt_r <= wait_cnt_r + WC_W'(1);
            end
          end else begin
            // Control opcodes finish in one cycle; conditions use acc as it entered EXEC.
            wait_cnt_r <= '0;
            state_r    <= ST_FETCH;
            case (opcode)
              OP_JMP: pc_r <= operand;
              OP_JGE: if (!acc_r[15]) pc_r <= operand;
              OP_JNE: if (acc_r != 16'h0000) pc_r <= operand;
              OP_STP: begin
                halted_r <= 1'b1;
                state_r  <= ST_HALT;
              end
              default: pc_r <= pc_r;
            endcase
          end
        end
        ST_HALT: begin
          wait_cnt_r <= '0;
          state_r    <= ST_HALT;
        end
        default: begin
          wait_cnt_r <= '0;
          state_r    <= ST_FETCH;
        end
      endcase
    end
  end

endmodule
